sfp_div_seq: RTL and testbench

//  Sequential signed fixed-point divider; upstream producer of sfp_if values.

---
 rtl/sfp_pkg.sv | 27 ++
 rtl/sfp_sat.sv | 27 ++
 rtl/sfp_div_seq.sv | 128 ++++++++++++
 tb/tb_sfp_div_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared types and helpers for the signed fixed-point (sfp) arithmetic blocks.
// Word lengths are passed at call time, so one package serves every format.
package sfp_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} sfp_div_state_e;

  localparam int SFP_MAX_W = 32;

  // Magnitude of a wl-bit two's complement value; the most negative input maps to 2^(wl-1).
  function automatic logic [SFP_MAX_W-1:0] sfp_abs(input logic [SFP_MAX_W-1:0] x, input int wl);
    logic [SFP_MAX_W-1:0] mask;
    logic [SFP_MAX_W-1:0] v;
    mask = (SFP_MAX_W'(1) << wl) - SFP_MAX_W'(1);
    v    = x & mask;
    if (v[wl-1]) return (~v + SFP_MAX_W'(1)) & mask;
    return v;
  endfunction

  function automatic logic [SFP_MAX_W-1:0] sfp_sat_max(input int wl);
    return (SFP_MAX_W'(1) << (wl - 1)) - SFP_MAX_W'(1);
  endfunction

  function automatic logic [SFP_MAX_W-1:0] sfp_sat_min(input int wl);
    return SFP_MAX_W'(1) << (wl - 1);
  endfunction

endpackage

// File: rtl/sfp_sat.sv
// Combinational saturator: clamps a wide signed value into an OUT_W-bit signed word.
// ovf is raised whenever the clamp replaces the value.
module sfp_sat #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  wide,
  output logic signed [OUT_W-1:0] narrow,
  output logic                    ovf
);

  logic [IN_W-OUT_W:0] head;

  // The value fits iff every bit from the output sign position upward is a copy of the sign.
  always_comb begin
    head = wide[IN_W-1:OUT_W-1];
    ovf  = !((head == '0) || (head == '1));
    if (!ovf) begin
      narrow = wide[OUT_W-1:0];
    end else if (wide[IN_W-1]) begin
      narrow = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      narrow = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sfp_div_seq.sv
// Sequential signed fixed-point divider, one restoring step per cycle, MSB first.
// Operands and quotient share the IW.QW format; the result is truncated toward zero and saturated.
module sfp_div_seq
  import sfp_pkg::*;
#(
  parameter int          IW = 4,
  parameter int unsigned QW = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic signed [IW+int'(QW)-1:0]    num,
  input  logic signed [IW+int'(QW)-1:0]    den,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic signed [IW+int'(QW)-1:0]    quo,
  output logic                             ovf_o,
  output logic                             dz_o
);

  localparam int WL = IW + int'(QW);
  localparam int LW = WL + int'(QW);
  localparam int CW = $clog2(LW);

  localparam logic signed [WL-1:0] Q_MAX = WL'(sfp_sat_max(WL));
  localparam logic signed [WL-1:0] Q_MIN = WL'(sfp_sat_min(WL));

  sfp_div_state_e state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           accept;

  logic [WL-1:0]  num_mag, den_mag_in, den_mag;
  logic           sign, num_neg, dz_pend;
  logic [LW-1:0]  dvd;
  logic [WL:0]    rem, trial;
  logic           ge;

  logic signed [LW:0]   wide;
  logic signed [WL-1:0] sat_q;
  logic                 sat_ovf;

  assign accept     = in_valid_i && (state == IDLE);
  assign num_mag    = WL'(sfp_abs(SFP_MAX_W'(num), WL));
  assign den_mag_in = WL'(sfp_abs(SFP_MAX_W'(den), WL));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CW'(LW - 1);
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_nxt = (den == '0) ? FIX : CALC;
      end
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring step: the quotient bits shift into dvd as the dividend bits shift out.
  assign trial = (rem << 1) | {{WL{1'b0}}, dvd[LW-1]};
  assign ge    = trial >= {1'b0, den_mag};

  always_ff @(posedge clk_i) begin
    if (accept) begin
      sign    <= num[WL-1] ^ den[WL-1];
      num_neg <= num[WL-1];
      dz_pend <= (den == '0);
      den_mag <= den_mag_in;
      dvd     <= {num_mag, {QW{1'b0}}};
      rem     <= '0;
    end else if (state == CALC) begin
      dvd <= {dvd[LW-2:0], ge};
      rem <= ge ? trial - {1'b0, den_mag} : trial;
    end
  end

  // Sign is reapplied to the unsigned quotient before clamping to WL bits.
  assign wide = sign ? -$signed({1'b0, dvd}) : $signed({1'b0, dvd});

  sfp_sat #(
    .IN_W (LW + 1),
    .OUT_W(WL)
  ) u_sat (
    .wide  (wide),
    .narrow(sat_q),
    .ovf   (sat_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo   <= '0;
      ovf_o <= 1'b0;
      dz_o  <= 1'b0;
    end else if (state == FIX) begin
      if (dz_pend) begin
        quo   <= num_neg ? Q_MIN : Q_MAX;
        ovf_o <= 1'b0;
        dz_o  <= 1'b1;
      end else begin
        quo   <= sat_q;
        ovf_o <= sat_ovf;
        dz_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfp_div_seq.sv
// Directed bench for sfp_div_seq: a rational-arithmetic model predicts each result and one
// process compares it against the DUT on every cycle a result is presented.
module tb_sfp_div_seq;

  localparam int IW = 4;
  localparam int QW = 4;
  localparam int WL = IW + QW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, ovf, dz;
  logic [WL-1:0] num, den, quo;

  int total = 0;
  int bad   = 0;

  logic [WL-1:0] m_q;
  logic          m_ovf, m_dz;

  sfp_div_seq #(.IW(IW), .QW(QW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .num        (num),
    .den        (den),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .quo        (quo),
    .ovf_o      (ovf),
    .dz_o       (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Quotient as the real ratio scaled by 2^QW, truncated toward zero, then clamped.
  function automatic void model(input logic [WL-1:0] n, input logic [WL-1:0] d,
                                output logic [WL-1:0] q, output logic o, output logic z);
    int ni, di, r, maxv, minv;
    ni   = int'($signed(n));
    di   = int'($signed(d));
    maxv = (1 << (WL - 1)) - 1;
    minv = -(1 << (WL - 1));
    o    = 1'b0;
    z    = 1'b0;
    if (di == 0) begin
      z = 1'b1;
      q = (ni < 0) ? WL'(minv) : WL'(maxv);
    end else begin
      r = (ni * (1 << QW)) / di;
      if (r > maxv) begin
        q = WL'(maxv);
        o = 1'b1;
      end else if (r < minv) begin
        q = WL'(minv);
        o = 1'b1;
      end else begin
        q = r[WL-1:0];
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      chk("quo", quo, m_q);
      chk("ovf", ovf, m_ovf);
      chk("dz", dz, m_dz);
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_quo"}, quo, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_dz"}, dz, 0);
  endtask

  task automatic do_op(input logic [WL-1:0] n, input logic [WL-1:0] d, input logic [WL-1:0] lq,
                       input logic lo, input logic lz, input int lat_exp, input int hold);
    int lat;
    @(negedge clk);
    num      = n;
    den      = d;
    in_valid = 1'b1;
    chk("ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num      = 8'hA5;
    den      = 8'h5A;
    model(n, d, m_q, m_ovf, m_dz);
    chk("model_q", m_q, lq);
    chk("model_ovf", m_ovf, lo);
    chk("model_dz", m_dz, lz);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 40);
    chk("latency", lat, lat_exp);
    chk("done_quo_lit", quo, lq);
    chk("done_not_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      num      = 8'h11;
      den      = 8'h22;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_not_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    num       = '0;
    den       = '0;
    @(posedge clk);
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h18, 8'h08, 8'h30, 1'b0, 1'b0, 14, 0);
    do_op(8'hE0, 8'h0C, 8'hD6, 1'b0, 1'b0, 14, 0);
    do_op(8'h70, 8'h01, 8'h7F, 1'b1, 1'b0, 14, 0);
    do_op(8'h80, 8'h10, 8'h80, 1'b0, 1'b0, 14, 0);
    do_op(8'h80, 8'hF0, 8'h7F, 1'b1, 1'b0, 14, 0);
    do_op(8'hF0, 8'h00, 8'h80, 1'b0, 1'b1, 2, 0);
    do_op(8'h00, 8'h00, 8'h7F, 1'b0, 1'b1, 2, 0);
    do_op(8'h10, 8'h30, 8'h05, 1'b0, 1'b0, 14, 0);
    do_op(8'hE8, 8'hF8, 8'h30, 1'b0, 1'b0, 14, 0);
    do_op(8'hEF, 8'h30, 8'hFB, 1'b0, 1'b0, 14, 0);

    // Result held under backpressure while new requests are offered
    do_op(8'h80, 8'hF0, 8'h7F, 1'b1, 1'b0, 14, 5);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    num      = 8'h18;
    den      = 8'h08;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("calc_busy", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h18, 8'h08, 8'h30, 1'b0, 1'b0, 14, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
